// File: rtl/fallthru_small_fifo_if.sv
// Handshake/data bundle for fallthru_small_fifo: producer/consumer side is
// the master, the FIFO itself is the slave.
interface fallthru_small_fifo_if #(
  parameter int unsigned WIDTH = 72
);
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, prog_full, empty
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, prog_full, empty
  );
endinterface

// File: rtl/fallthru_small_fifo.sv
// Small first-word-fall-through FIFO, depth 2**MAX_DEPTH_BITS, flags decoded from a registered count.
// Define FALLTHRU_FIFO_ERROR_CHECK_EN to compile in simulation-only overflow/underflow messages.
module fallthru_small_fifo #(
  parameter int unsigned WIDTH               = 72,
  parameter int unsigned MAX_DEPTH_BITS      = 3,
  parameter int unsigned PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  fallthru_small_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam int unsigned PW    = MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             wr_acc;
  logic             rd_acc;
  logic             empty_q;
  logic             full_q;
  logic             nearly_full_q;
  logic             prog_full_q;

  // Acceptance uses the registered flags, so a write into a full FIFO is dropped
  // even when a read frees a slot at the same edge.
  always_comb begin
    wr_acc     = bus.wr_en && !full_q;
    rd_acc     = bus.rd_en && !empty_q;
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      nearly_full_q <= 1'b0;
      prog_full_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count         <= count_next;
      empty_q       <= (count_next == '0);
      full_q        <= (count_next == CW'(DEPTH));
      nearly_full_q <= (count_next >= CW'(DEPTH - 1));
      prog_full_q   <= (count_next >= CW'(PROG_FULL_THRESHOLD));
    end
  end

  // Storage has no reset; only the head view is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.din;
  end

  assign bus.dout        = empty_q ? '0 : mem[rd_ptr];
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.nearly_full = nearly_full_q;
  assign bus.prog_full   = prog_full_q;

`ifdef FALLTHRU_FIFO_ERROR_CHECK_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && bus.wr_en && full_q)
      $error("%m: write while full at time %0t", $time);
    if (!reset && bus.rd_en && empty_q)
      $error("%m: read while empty at time %0t", $time);
  end
`endif
`endif

endmodule

// File: tb/tb_fallthru_small_fifo.sv
// Directed self-checking bench for fallthru_small_fifo (WIDTH=32, DEPTH=4, prog_full threshold 2).
module tb_fallthru_small_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned MDB   = 2;
  localparam int unsigned PFT   = 2;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  fallthru_small_fifo_if #(.WIDTH(WIDTH)) bus ();

  fallthru_small_fifo #(
    .WIDTH              (WIDTH),
    .MAX_DEPTH_BITS     (MDB),
    .PROG_FULL_THRESHOLD(PFT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    bus.din   = v;
    bus.wr_en = 1'b1;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic flags(input string tag, input logic e, input logic f, input logic nf, input logic pf);
    check({tag, ".empty"},       32'(bus.empty),       32'(e));
    check({tag, ".full"},        32'(bus.full),        32'(f));
    check({tag, ".nearly_full"}, 32'(bus.nearly_full), 32'(nf));
    check({tag, ".prog_full"},   32'(bus.prog_full),   32'(pf));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Fill completely, then hit reset asynchronously mid-cycle.
    for (int i = 1; i <= 4; i++) push(32'(i + 100));
    flags("prefill", 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    flags("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("async_rst.dout", bus.dout, 32'h0);
    step();
    reset = 1'b0;
    step();
    flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Fall-through: word appears without rd_en.
    push(32'hA5A5);
    flags("ft1", 1'b0, 1'b0, 1'b0, 1'b0);
    check("ft1.dout", bus.dout, 32'hA5A5);
    step();
    check("ft2.dout", bus.dout, 32'hA5A5);
    pop();
    flags("ft3", 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill to full; 5th write dropped.
    push(32'd1);
    flags("fill1", 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'd2);
    flags("fill2", 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd3);
    flags("fill3", 1'b0, 1'b0, 1'b1, 1'b1);
    push(32'd4);
    flags("fill4", 1'b0, 1'b1, 1'b1, 1'b1);
    push(32'd5);
    flags("fill5", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d.dout", i), bus.dout, 32'(i));
      pop();
    end
    flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);

    // Full with simultaneous read and write: read wins, 9 dropped.
    for (int i = 1; i <= 4; i++) push(32'(i));
    bus.din   = 32'd9;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    flags("fullrw", 1'b0, 1'b0, 1'b1, 1'b1);
    check("fullrw.dout", bus.dout, 32'd2);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("fullrw_drain%0d.dout", i), bus.dout, 32'(i));
      pop();
    end
    flags("fullrw_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Streaming across pointer wrap: read on the first cycle is ignored (empty).
    bus.din   = 32'd0;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    step();
    flags("stream0", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      check($sformatf("stream%0d.dout", i - 1), bus.dout, 32'(i - 1));
      bus.din = 32'(i);
      step();
      flags($sformatf("stream%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.wr_en = 1'b0;
    check("stream19.dout", bus.dout, 32'd19);
    step();
    bus.rd_en = 1'b0;
    flags("stream_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Underflow then prog_full threshold crossing.
    pop();
    flags("underflow", 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'h11);
    flags("pf1", 1'b0, 1'b0, 1'b0, 1'b0);
    check("pf1.dout", bus.dout, 32'h11);
    push(32'h22);
    flags("pf2", 1'b0, 1'b0, 1'b0, 1'b1);
    pop();
    flags("pf3", 1'b0, 1'b0, 1'b0, 1'b0);
    check("pf3.dout", bus.dout, 32'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fallthru_small_fifo.md
Name: fallthru_small_fifo

Overview:
- Small synchronous first-word-fall-through (FWFT) FIFO with depth 2^MAX_DEPTH_BITS.
- The head word is always presented on dout whenever empty is low. rd_en acknowledges and pops that word; it does not request it.
- Used as a general queue in the datapath, for example a rank/metadata queue inside the rank pipelines. Upstream throttles on nearly_full.

Parameters:
- WIDTH, 72: data word width in bits.
- MAX_DEPTH_BITS, 3: log2 of the storage depth. DEPTH = 2^MAX_DEPTH_BITS entries.
- PROG_FULL_THRESHOLD, 2^MAX_DEPTH_BITS - 1: occupancy at or above which prog_full asserts. Legal range is 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write strobe. Pushes din at the clock edge when not full.
- rd_en  in  1  pop strobe. Discards the current head word at the clock edge when not empty.
- dout  out  WIDTH  current head word. Valid only while empty=0.
- full  out  1  occupancy == DEPTH.
- nearly_full  out  1  occupancy >= DEPTH-1.
- prog_full  out  1  occupancy >= PROG_FULL_THRESHOLD.
- empty  out  1  no word is available on dout.

Behaviour:
- Storage:
  - DEPTH x WIDTH register/LUT array.
  - Write pointer and read pointer, each MAX_DEPTH_BITS wide; both wrap modulo DEPTH.
  - Occupancy counter, MAX_DEPTH_BITS+1 bits wide, range 0..DEPTH.
- Reset (asserted asynchronously, takes effect immediately):
  - Pointers and count go to 0.
  - Outputs: empty=1, full=0, nearly_full=0, prog_full=0.
  - dout goes to all zeros.
  - Array contents are don't-care.
  - Reset during traffic discards all stored words. The first write after reset release is accepted normally.
- Write acceptance:
  - A write is accepted when wr_en=1 and full=0 at the edge.
  - din is stored at the write pointer, the pointer increments, and the count increments.
- Read acceptance:
  - A read is accepted when rd_en=1 and empty=0 at the edge.
  - The read pointer increments and the count decrements.
- Fall-through latency:
  - A word written into an empty FIFO at edge N appears on dout with empty=0 after edge N (one-cycle latency). No rd_en is needed to fetch it.
  - After an accepted read, dout shows the next word in the following cycle, or empty asserts if none remains.
- dout:
  - dout equals array[read pointer] (combinational read of the head).
  - Its value while empty=1 is unspecified, except after reset when it is zero.
- Simultaneous write and read with 0 < count < DEPTH: both are accepted, the count is unchanged, and order is preserved.
- Simultaneous write and read when empty: the write is accepted, the read is ignored, and the count becomes 1.
- Simultaneous write and read when full: the read is accepted and the write is dropped (full is evaluated before the edge). The count becomes DEPTH-1.
- Overflow (wr_en while full): data is dropped and no state changes.
- Underflow (rd_en while empty): ignored and no state changes.
- Flags:
  - All flags are registered, or decoded from the registered count, so they are glitch-free and update in the cycle after the causing edge.
  - Flags derive purely from the count.
- Wrap-around: pointers roll over from DEPTH-1 to 0 with no bubble, so sustained one-write-one-read runs indefinitely.

Optional Feature:
- Macro: FALLTHRU_FIFO_ERROR_CHECK_EN.
- When defined, simulation-only checks are compiled in:
  - At every edge with wr_en=1 and full=1, print an error naming the instance (%m) and the simulation time.
  - At every edge with rd_en=1 and empty=1, print the same kind of error.
  - These checks are excluded from synthesis.
- When undefined, no checks are emitted. Functional behaviour is identical in both cases.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset asynchronously mid-cycle.
  - Response: empty=1, full=0, nearly_full=0, prog_full=0 and dout=0 immediately, without waiting for a clock edge.
- Fall-through (WIDTH=32, MAX_DEPTH_BITS=2):
  - Stimulus: write 0xA5A5 at edge 1.
  - Response: after edge 1, empty=0 and dout=0xA5A5 with no rd_en.
  - Stimulus: rd_en at edge 3.
  - Response: empty=1 after edge 3.
- Fill to full (DEPTH=4):
  - Stimulus: write 1,2,3,4, then a 5th write of value 5.
  - Response: nearly_full asserts after the 3rd write. full asserts after the 4th write. The 5th write is dropped.
  - Stimulus: read four times.
  - Response: dout sequence is 1,2,3,4 and empty=1 after the last read.
- Full with simultaneous rd/wr:
  - Stimulus: with the FIFO full (1..4), assert wr_en=1 (din=9) and rd_en=1 together.
  - Response: count becomes 3, full=0, head becomes 2, and 9 is not stored.
- Wrap-around streaming:
  - Stimulus: write and read every cycle for 20 words (values 0..19).
  - Response: dout delivers 0..19 in order, count stays at 1 and no flag toggles beyond the first empty deassertion.
- Underflow and prog_full (PROG_FULL_THRESHOLD=2):
  - Stimulus: rd_en while empty.
  - Response: no change to any output.
  - Stimulus: two writes.
  - Response: prog_full asserts after the 2nd write.
  - Stimulus: one read.
  - Response: prog_full deasserts.
